// File: rtl/sodor_fetch_pkg.sv
// Shared types and constants for the Sodor 2-stage fetch controller.
package sodor_fetch_pkg;

    localparam logic [31:0] BUBBLE_INST = 32'h0000_4033;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'd0,
        PC_BRJMP = 2'd1,
        PC_JALR  = 2'd2,
        PC_EXC   = 2'd3
    } pc_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/sodor_fetch_inst_buffer.sv
// One-entry skid buffer holding a fetched instruction while EXE is stalled.
module sodor_fetch_inst_buffer #(
    parameter int unsigned     W          = 32,
    parameter logic [W-1:0]    RESET_DATA = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load_i,
    input  logic         unload_i,
    input  logic         flush_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         valid_o
);

    logic [W-1:0] data_q;
    logic         valid_q;

    // Flush beats load beats unload; data only changes on load.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_q  <= RESET_DATA;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
        end else if (unload_i) begin
            valid_q <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/sodor_2stage_fetch_ctrl.sv
// IF-stage sequencer: PC, single-outstanding imem handshake, skid buffer, IF->EXE register.
module sodor_2stage_fetch_ctrl
    import sodor_fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0]     BUBBLE   = BUBBLE_INST
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            exe_stall,
    input  logic [1:0]      pc_sel,
    input  logic [XLEN-1:0] br_target,
    input  logic [XLEN-1:0] jalr_target,
    input  logic [XLEN-1:0] exc_target,
    output logic [XLEN-1:0] if_reg_pc,
    output logic [XLEN-1:0] exe_reg_pc,
    output logic [31:0]     exe_reg_inst,
    output logic            exe_valid,
    output logic            if_kill,
    output logic            inst_buffer_valid
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] exe_pc_q, exe_pc_d;
    logic [31:0]     exe_inst_q, exe_inst_d;
    logic            exe_valid_q, exe_valid_d;
    logic            kill_q, kill_d;
    logic            drop_q, drop_d;
    logic            req_valid_q, req_valid_d;

    logic            buf_load, buf_unload, buf_flush, buf_valid;
    logic [31:0]     buf_data;
    logic [XLEN-1:0] redirect_target;
    logic            req_fire, redirect, outstanding;

    sodor_fetch_inst_buffer #(
        .W          (32),
        .RESET_DATA (BUBBLE)
    ) u_inst_buffer (
        .clock    (clock),
        .reset    (reset),
        .load_i   (buf_load),
        .unload_i (buf_unload),
        .flush_i  (buf_flush),
        .data_i   (imem_resp_data),
        .data_o   (buf_data),
        .valid_o  (buf_valid)
    );

    assign req_fire    = req_valid_q & imem_req_ready;
    assign redirect    = exe_valid_q & ~exe_stall & (pc_sel != 2'(PC_PLUS4));
    // A request is still in flight if it fires now or a WAIT has not seen its response yet.
    assign outstanding = req_fire | ((state_q == ST_WAIT) & ~imem_resp_valid);

    // Redirect target select.
    always_comb begin
        redirect_target = pc_q;
        case (pc_sel_e'(pc_sel))
            PC_BRJMP: redirect_target = br_target;
            PC_JALR:  redirect_target = jalr_target;
            PC_EXC:   redirect_target = exc_target;
            default:  redirect_target = pc_q;
        endcase
    end

    // Next-state and datapath control; a redirect overrides everything else.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        exe_pc_d    = exe_pc_q;
        exe_inst_d  = exe_inst_q;
        exe_valid_d = exe_valid_q;
        kill_d      = 1'b0;
        drop_d      = drop_q;
        buf_load    = 1'b0;
        buf_unload  = 1'b0;
        buf_flush   = 1'b0;

        if (!exe_stall) begin
            exe_pc_d    = '0;
            exe_inst_d  = BUBBLE;
            exe_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (req_fire) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_resp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else if (!exe_stall) begin
                        exe_pc_d    = pc_q;
                        exe_inst_d  = imem_resp_data;
                        exe_valid_d = 1'b1;
                        pc_d        = pc_q + XLEN'(4);
                        state_d     = ST_REQ;
                    end else begin
                        buf_load = 1'b1;
                        state_d  = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!exe_stall) begin
                    exe_pc_d    = pc_q;
                    exe_inst_d  = buf_data;
                    exe_valid_d = 1'b1;
                    pc_d        = pc_q + XLEN'(4);
                    buf_unload  = 1'b1;
                    state_d     = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (redirect) begin
            pc_d        = redirect_target & ~XLEN'(3);
            exe_pc_d    = '0;
            exe_inst_d  = BUBBLE;
            exe_valid_d = 1'b0;
            buf_load    = 1'b0;
            buf_unload  = 1'b0;
            buf_flush   = 1'b1;
            kill_d      = 1'b1;
            if (outstanding) begin
                state_d = ST_WAIT;
                drop_d  = 1'b1;
            end else begin
                state_d = ST_REQ;
                drop_d  = 1'b0;
            end
        end

        req_valid_d = (state_d == ST_REQ);
    end

    // State and pipeline registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            exe_pc_q    <= '0;
            exe_inst_q  <= BUBBLE;
            exe_valid_q <= 1'b0;
            kill_q      <= 1'b1;
            drop_q      <= 1'b0;
            req_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            exe_pc_q    <= exe_pc_d;
            exe_inst_q  <= exe_inst_d;
            exe_valid_q <= exe_valid_d;
            kill_q      <= kill_d;
            drop_q      <= drop_d;
            req_valid_q <= req_valid_d;
        end
    end

    assign imem_req_valid    = req_valid_q;
    assign imem_req_addr     = pc_q;
    assign if_reg_pc         = pc_q;
    assign exe_reg_pc        = exe_pc_q;
    assign exe_reg_inst      = exe_inst_q;
    assign exe_valid         = exe_valid_q;
    assign if_kill           = kill_q;
    assign inst_buffer_valid = buf_valid;

endmodule

// File: tb/tb_sodor_2stage_fetch_ctrl.sv
// Directed bench for the Sodor 2-stage fetch controller.
module tb_sodor_2stage_fetch_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        exe_stall = 1'b0;
    logic [1:0]  pc_sel = 2'd0;
    logic [31:0] br_target = 32'h0;
    logic [31:0] jalr_target = 32'h0;
    logic [31:0] exc_target = 32'h0;
    logic [31:0] if_reg_pc;
    logic [31:0] exe_reg_pc;
    logic [31:0] exe_reg_inst;
    logic        exe_valid;
    logic        if_kill;
    logic        inst_buffer_valid;

    int tests = 0;
    int fails = 0;

    sodor_2stage_fetch_ctrl #(
        .XLEN     (32),
        .RESET_PC (32'h0),
        .BUBBLE   (32'h0000_4033)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .imem_req_valid    (imem_req_valid),
        .imem_req_addr     (imem_req_addr),
        .imem_req_ready    (imem_req_ready),
        .imem_resp_valid   (imem_resp_valid),
        .imem_resp_data    (imem_resp_data),
        .exe_stall         (exe_stall),
        .pc_sel            (pc_sel),
        .br_target         (br_target),
        .jalr_target       (jalr_target),
        .exc_target        (exc_target),
        .if_reg_pc         (if_reg_pc),
        .exe_reg_pc        (exe_reg_pc),
        .exe_reg_inst      (exe_reg_inst),
        .exe_valid         (exe_valid),
        .if_kill           (if_kill),
        .inst_buffer_valid (inst_buffer_valid)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_if_pc"},    if_reg_pc, 32'h0);
        chk({tag, "_exe_pc"},   exe_reg_pc, 32'h0);
        chk({tag, "_exe_inst"}, exe_reg_inst, 32'h0000_4033);
        chk({tag, "_exe_vld"},  32'(exe_valid), 32'd0);
        chk({tag, "_kill"},     32'(if_kill), 32'd1);
        chk({tag, "_buf_vld"},  32'(inst_buffer_valid), 32'd0);
        chk({tag, "_req_vld"},  32'(imem_req_valid), 32'd0);
    endtask

    initial begin
        // Reset values
        tick();
        tick();
        chk_reset_values("rst");
        reset = 1'b0;

        // Basic fetch: E1 first request
        tick();
        chk("e1_req_vld", 32'(imem_req_valid), 32'd1);
        chk("e1_addr", imem_req_addr, 32'h0);
        chk("e1_kill_fall", 32'(if_kill), 32'd0);
        tick();                                         // E2 WAIT
        chk("e2_req_vld", 32'(imem_req_valid), 32'd0);
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0013;
        tick();                                         // E3 advance pc 0
        imem_resp_valid = 1'b0;
        chk("e3_exe_vld", 32'(exe_valid), 32'd1);
        chk("e3_exe_pc", exe_reg_pc, 32'h0);
        chk("e3_exe_inst", exe_reg_inst, 32'h0000_0013);
        chk("e3_addr", imem_req_addr, 32'h4);
        chk("e3_req_vld", 32'(imem_req_valid), 32'd1);
        tick();                                         // E4 WAIT, EXE bubbles
        chk("e4_exe_vld", 32'(exe_valid), 32'd0);
        imem_resp_valid = 1'b1;
        tick();                                         // E5 advance pc 4
        imem_resp_valid = 1'b0;
        chk("e5_exe_pc", exe_reg_pc, 32'h4);
        chk("e5_addr", imem_req_addr, 32'h8);

        // Stall: response captured in buffer for 3 cycles
        exe_stall = 1'b1;
        tick();                                         // E6 WAIT, EXE held
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0050_0093;
        tick();                                         // E7 HOLD
        imem_resp_valid = 1'b0;
        chk("e7_buf_vld", 32'(inst_buffer_valid), 32'd1);
        chk("e7_exe_pc_held", exe_reg_pc, 32'h4);
        chk("e7_req_vld", 32'(imem_req_valid), 32'd0);
        tick();                                         // E8
        chk("e8_buf_vld", 32'(inst_buffer_valid), 32'd1);
        chk("e8_req_vld", 32'(imem_req_valid), 32'd0);
        tick();                                         // E9
        chk("e9_buf_vld", 32'(inst_buffer_valid), 32'd1);
        exe_stall = 1'b0;
        tick();                                         // E10 buffer -> EXE
        chk("e10_buf_vld", 32'(inst_buffer_valid), 32'd0);
        chk("e10_exe_pc", exe_reg_pc, 32'h8);
        chk("e10_exe_inst", exe_reg_inst, 32'h0050_0093);
        chk("e10_if_pc", if_reg_pc, 32'hC);
        chk("e10_req_vld", 32'(imem_req_valid), 32'd1);

        // BRJMP while the request fires: stale response must be dropped
        pc_sel = 2'd1; br_target = 32'h100;
        tick();                                         // E11
        pc_sel = 2'd0;
        chk("br_if_pc", if_reg_pc, 32'h100);
        chk("br_kill", 32'(if_kill), 32'd1);
        chk("br_exe_pc", exe_reg_pc, 32'h0);
        chk("br_exe_inst", exe_reg_inst, 32'h0000_4033);
        chk("br_exe_vld", 32'(exe_valid), 32'd0);
        chk("br_req_vld", 32'(imem_req_valid), 32'd0);
        imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
        tick();                                         // E12 stale dropped
        imem_resp_valid = 1'b0;
        chk("drop_kill", 32'(if_kill), 32'd0);
        chk("drop_exe_inst", exe_reg_inst, 32'h0000_4033);
        chk("drop_exe_vld", 32'(exe_valid), 32'd0);
        chk("drop_req_vld", 32'(imem_req_valid), 32'd1);
        chk("drop_addr", imem_req_addr, 32'h100);
        tick();                                         // E13 WAIT
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0013;
        tick();                                         // E14
        imem_resp_valid = 1'b0;
        chk("br_tgt_exe_pc", exe_reg_pc, 32'h100);

        // EXC redirect with misaligned target, no request in flight
        imem_req_ready = 1'b0; pc_sel = 2'd3; exc_target = 32'h8000_0003;
        tick();                                         // E15
        pc_sel = 2'd0; imem_req_ready = 1'b1;
        chk("exc_if_pc", if_reg_pc, 32'h8000_0000);
        chk("exc_kill", 32'(if_kill), 32'd1);
        chk("exc_req_vld", 32'(imem_req_valid), 32'd1);
        tick();                                         // E16 WAIT
        imem_resp_valid = 1'b1;
        tick();                                         // E17
        imem_resp_valid = 1'b0;
        chk("exc_exe_pc", exe_reg_pc, 32'h8000_0000);

        // Redirect and response on the same cycle
        exe_stall = 1'b1;
        tick();                                         // E18 WAIT, EXE held
        chk("held_exe_vld", 32'(exe_valid), 32'd1);
        exe_stall = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'hCAFE_0001;
        pc_sel = 2'd2; jalr_target = 32'h201;
        tick();                                         // E19
        imem_resp_valid = 1'b0; pc_sel = 2'd0;
        chk("jalr_if_pc", if_reg_pc, 32'h200);
        chk("jalr_exe_inst", exe_reg_inst, 32'h0000_4033);
        chk("jalr_exe_vld", 32'(exe_valid), 32'd0);
        chk("jalr_req_vld", 32'(imem_req_valid), 32'd1);
        tick();                                         // E20 WAIT
        chk("jalr_no_stale", exe_reg_inst, 32'h0000_4033);
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0013;
        tick();                                         // E21
        imem_resp_valid = 1'b0;
        chk("jalr_exe_pc", exe_reg_pc, 32'h200);
        chk("jalr_exe_inst2", exe_reg_inst, 32'h0000_0013);

        // PC wrap from 0xFFFFFFFC
        imem_req_ready = 1'b0; pc_sel = 2'd1; br_target = 32'hFFFF_FFFC;
        tick();                                         // E22
        pc_sel = 2'd0; imem_req_ready = 1'b1;
        chk("wrap_if_pc", if_reg_pc, 32'hFFFF_FFFC);
        tick();                                         // E23 WAIT
        imem_resp_valid = 1'b1;
        tick();                                         // E24
        imem_resp_valid = 1'b0;
        chk("wrap_exe_pc", exe_reg_pc, 32'hFFFF_FFFC);
        chk("wrap_addr", imem_req_addr, 32'h0);

        // Reset asserted mid-cycle while in HOLD
        exe_stall = 1'b1;
        tick();                                         // E25 WAIT
        imem_resp_valid = 1'b1;
        tick();                                         // E26 HOLD
        imem_resp_valid = 1'b0;
        chk("hold_buf_vld", 32'(inst_buffer_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_values("async_rst");
        tick();
        reset = 1'b0; exe_stall = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_data = 32'hBAD0_BAD0;
        tick();                                         // IDLE -> REQ, stale response ignored
        imem_resp_valid = 1'b0;
        chk("post_rst_req_vld", 32'(imem_req_valid), 32'd1);
        chk("post_rst_addr", imem_req_addr, 32'h0);
        chk("post_rst_exe_vld", 32'(exe_valid), 32'd0);
        chk("post_rst_exe_inst", exe_reg_inst, 32'h0000_4033);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
